pc_next_unit: RTL and testbench

PC_NEXT_UNIT -- requirements
Module: pc_next_unit

---
 rtl/pc_next_unit.sv | 116 +++++++++++
 tb/tb_pc_next_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pc_next_unit.sv
// Next-PC selection with redirect flush and an optional circular return-address stack.
// Define PC_NEXT_RAS_EN to build the return stack; otherwise returns target ret_addr_i.
module pc_next_unit #(
  parameter int unsigned     PC_W      = 16,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 PCSrc,
  input  logic                       stall_i,
  input  logic [PC_W-1:0]            jump_tgt_i,
  input  logic [PC_W-1:0]            br_tgt_i,
  input  logic                       call_i,
  input  logic [PC_W-1:0]            link_addr_i,
  input  logic [PC_W-1:0]            ret_addr_i,
  output logic [PC_W-1:0]            pc_o,
  output logic                       flush_o,
  output logic [$clog2(RAS_DEPTH):0] ras_cnt_o,
  output logic                       ras_err_o
);

  localparam int unsigned CNT_W = $clog2(RAS_DEPTH) + 1;

  logic            redirect;
  logic [PC_W-1:0] ret_tgt;
  logic [PC_W-1:0] tgt_sel;
  logic [PC_W-1:0] pc_nxt;

  assign redirect = (PCSrc != 2'b00);

  always_comb begin
    tgt_sel = jump_tgt_i;
    case (PCSrc)
      2'b10:   tgt_sel = br_tgt_i;
      2'b11:   tgt_sel = ret_tgt;
      default: tgt_sel = jump_tgt_i;
    endcase
    if (redirect)
      pc_nxt = tgt_sel;
    else if (stall_i)
      pc_nxt = pc_o;
    else
      pc_nxt = pc_o + PC_W'(1);
  end

  // Fetch PC register; a redirect overrides stall and flushes IF/ID next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_o    <= RESET_PC;
      flush_o <= 1'b0;
    end else begin
      pc_o    <= pc_nxt;
      flush_o <= redirect;
    end
  end

`ifdef PC_NEXT_RAS_EN
  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);

  logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] sp;
  logic [CNT_W-1:0] cnt;
  logic             err;
  logic             push;
  logic             pop;
  logic             empty;
  logic             full;
  logic             unused_ret;

  assign push       = (PCSrc == 2'b01) && call_i;
  assign pop        = (PCSrc == 2'b11);
  assign empty      = (cnt == '0);
  assign full       = (cnt == CNT_W'(RAS_DEPTH));
  assign ret_tgt    = empty ? RESET_PC : ras_mem[sp - PTR_W'(1)];
  assign unused_ret = ^ret_addr_i;

  // sp always points at the next free slot; when full that slot holds the oldest entry
  always_ff @(posedge clk) begin
    if (push)
      ras_mem[sp] <= link_addr_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp  <= '0;
      cnt <= '0;
      err <= 1'b0;
    end else if (push) begin
      sp <= sp + PTR_W'(1);
      if (full)
        err <= 1'b1;
      else
        cnt <= cnt + CNT_W'(1);
    end else if (pop) begin
      if (empty) begin
        err <= 1'b1;
      end else begin
        sp  <= sp - PTR_W'(1);
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign ras_cnt_o = cnt;
  assign ras_err_o = err;
`else
  logic unused_ras;

  assign ret_tgt    = ret_addr_i;
  assign unused_ras = call_i ^ (^link_addr_i);
  assign ras_cnt_o  = '0;
  assign ras_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
// Scoreboard bench for pc_next_unit: stimulus queues expected post-edge state, a monitor compares.
module tb_pc_next_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  PCSrc;
  logic        stall_i;
  logic [15:0] jump_tgt_i;
  logic [15:0] br_tgt_i;
  logic        call_i;
  logic [15:0] link_addr_i;
  logic [15:0] ret_addr_i;
  logic [15:0] pc_o;
  logic        flush_o;
  logic [2:0]  ras_cnt_o;
  logic        ras_err_o;

  typedef struct packed {
    logic [15:0] pc;
    logic        fl;
    logic [2:0]  cnt;
    logic        er;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_vec = 0;

  pc_next_unit #(.PC_W(16), .RESET_PC(16'h0000), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .PCSrc(PCSrc), .stall_i(stall_i),
    .jump_tgt_i(jump_tgt_i), .br_tgt_i(br_tgt_i), .call_i(call_i),
    .link_addr_i(link_addr_i), .ret_addr_i(ret_addr_i), .pc_o(pc_o),
    .flush_o(flush_o), .ras_cnt_o(ras_cnt_o), .ras_err_o(ras_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the state expected after the next rising edge
  task automatic step(input logic [1:0] src, input logic st, input logic [15:0] tgt,
                      input logic cl, input logic [15:0] lk, input logic [15:0] ra,
                      input logic [15:0] epc, input logic efl, input logic [2:0] ecnt,
                      input logic eer);
    exp_t e;
    PCSrc       = src;
    stall_i     = st;
    jump_tgt_i  = (src == 2'b10) ? ~tgt : tgt;
    br_tgt_i    = (src == 2'b10) ? tgt : ~tgt;
    call_i      = cl;
    link_addr_i = lk;
    ret_addr_i  = ra;
    e.pc = epc; e.fl = efl; e.cnt = ecnt; e.er = eer;
    q.push_back(e);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk($sformatf("v%0d pc_o", n_vec), 32'(pc_o), 32'(e.pc));
      chk($sformatf("v%0d flush_o", n_vec), 32'(flush_o), 32'(e.fl));
      chk($sformatf("v%0d ras_cnt_o", n_vec), 32'(ras_cnt_o), 32'(e.cnt));
      chk($sformatf("v%0d ras_err_o", n_vec), 32'(ras_err_o), 32'(e.er));
      n_vec++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; PCSrc = 2'b00; stall_i = 1'b0; jump_tgt_i = '0; br_tgt_i = '0;
    call_i = 1'b0; link_addr_i = '0; ret_addr_i = '0;
    repeat (2) @(negedge clk);
    chk("reset pc_o", 32'(pc_o), 32'h0);
    chk("reset flush_o", 32'(flush_o), 32'h0);
    chk("reset ras_cnt_o", 32'(ras_cnt_o), 32'h0);
    chk("reset ras_err_o", 32'(ras_err_o), 32'h0);
    rst_n = 1'b1;

    // Free-running sequential fetch
    for (int i = 1; i <= 5; i++)
      step(2'b00, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 16'(i), 1'b0, 3'd0, 1'b0);

    // Branch beats stall, then stall holds
    step(2'b10, 1'b1, 16'h0040, 1'b0, 16'h0, 16'h0, 16'h0040, 1'b1, 3'd0, 1'b0);
    step(2'b00, 1'b1, 16'h0, 1'b0, 16'h0, 16'h0, 16'h0040, 1'b0, 3'd0, 1'b0);
    step(2'b00, 1'b1, 16'h0, 1'b0, 16'h0, 16'h0, 16'h0040, 1'b0, 3'd0, 1'b0);
    step(2'b00, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 16'h0041, 1'b0, 3'd0, 1'b0);

    // Back-to-back redirects keep flush high
    step(2'b01, 1'b0, 16'h0100, 1'b0, 16'h0, 16'h0, 16'h0100, 1'b1, 3'd0, 1'b0);
    step(2'b01, 1'b1, 16'h0200, 1'b0, 16'h0, 16'h0, 16'h0200, 1'b1, 3'd0, 1'b0);
    step(2'b00, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 16'h0201, 1'b0, 3'd0, 1'b0);

    // Wrap from all ones
    step(2'b01, 1'b0, 16'hFFFF, 1'b0, 16'h0, 16'h0, 16'hFFFF, 1'b1, 3'd0, 1'b0);
    step(2'b00, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 16'h0000, 1'b0, 3'd0, 1'b0);

    // Asynchronous reset in the middle of a jump cycle, right after a redirect
    step(2'b01, 1'b0, 16'h0777, 1'b0, 16'h0, 16'h0, 16'h0777, 1'b1, 3'd0, 1'b0);
    PCSrc = 2'b01; jump_tgt_i = 16'h3333; br_tgt_i = 16'h0;
    #2 rst_n = 1'b0;
    #1;
    chk("async reset pc_o", 32'(pc_o), 32'h0);
    chk("async reset flush_o", 32'(flush_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(2'b00, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 16'h0001, 1'b0, 3'd0, 1'b0);

`ifdef PC_NEXT_RAS_EN
    // call_i ignored on a branch
    step(2'b10, 1'b0, 16'h0090, 1'b1, 16'hAAAA, 16'h0, 16'h0090, 1'b1, 3'd0, 1'b0);
    // Three calls then three returns
    step(2'b01, 1'b0, 16'h0050, 1'b1, 16'h0010, 16'h0, 16'h0050, 1'b1, 3'd1, 1'b0);
    step(2'b01, 1'b0, 16'h0060, 1'b1, 16'h0020, 16'h0, 16'h0060, 1'b1, 3'd2, 1'b0);
    step(2'b01, 1'b0, 16'h0070, 1'b1, 16'h0030, 16'h0, 16'h0070, 1'b1, 3'd3, 1'b0);
    step(2'b11, 1'b0, 16'h0, 1'b0, 16'h0, 16'hBEEF, 16'h0030, 1'b1, 3'd2, 1'b0);
    step(2'b11, 1'b0, 16'h0, 1'b0, 16'h0, 16'hBEEF, 16'h0020, 1'b1, 3'd1, 1'b0);
    step(2'b11, 1'b0, 16'h0, 1'b0, 16'h0, 16'hBEEF, 16'h0010, 1'b1, 3'd0, 1'b0);
    step(2'b00, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 16'h0011, 1'b0, 3'd0, 1'b0);
    // Five pushes overflow a depth-4 stack, five returns underflow it
    for (int i = 1; i <= 5; i++)
      step(2'b01, 1'b0, 16'h0080, 1'b1, 16'(i), 16'h0, 16'h0080, 1'b1,
           (i < 4) ? 3'(i) : 3'd4, (i == 5));
    for (int i = 5; i >= 2; i--)
      step(2'b11, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 16'(i), 1'b1, 3'(i - 2), 1'b1);
    step(2'b11, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 16'h0000, 1'b1, 3'd0, 1'b1);
    step(2'b00, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 16'h0001, 1'b0, 3'd0, 1'b1);
    // Underflow alone on an empty stack after reset
    rst_n = 1'b0;
    #1;
    chk("reset clears ras_err_o", 32'(ras_err_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(2'b11, 1'b0, 16'h0, 1'b0, 16'h0, 16'h4321, 16'h0000, 1'b1, 3'd0, 1'b1);
`else
    // Returns use ret_addr_i; calls leave no trace
    step(2'b11, 1'b0, 16'h0, 1'b0, 16'h0, 16'h1234, 16'h1234, 1'b1, 3'd0, 1'b0);
    step(2'b01, 1'b0, 16'h0050, 1'b1, 16'h0010, 16'h0, 16'h0050, 1'b1, 3'd0, 1'b0);
    step(2'b11, 1'b0, 16'h0, 1'b0, 16'h0, 16'h5678, 16'h5678, 1'b1, 3'd0, 1'b0);
    step(2'b00, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 16'h5679, 1'b0, 3'd0, 1'b0);
`endif

    PCSrc = 2'b00; stall_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("scoreboard drained", 32'(q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
